math_cabs_seq: RTL

- Parametrised, handshaked complex-magnitude unit for the signal-processing math library.
- Computes the exact integer |z|^2 = a^2 + b^2, or |z| = sqrt(a^2 + b^2), for signed I/Q samples.
- Mode is selected per sample; |z| is either floored or rounded to nearest.
- Replaces fixed-width log2/pow2 approximations with an exact bit-serial square root, behind valid/ready handshakes for use between streaming stages.

---
 rtl/math_cabs_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/math_cabs_seq.sv
// Complex-magnitude unit: |z|^2 = a^2 + b^2 (mode 0) or |z| = sqrt(a^2 + b^2)
// (mode 1, floored or rounded to nearest per ROUND), behind valid/ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready high only in IDLE
//   dina, dinb          signed real / imaginary parts (WIDTH bits)
//   mode                0 = |z|^2, 1 = |z|
//   tag_in              sideband tag carried with the sample
//   out_valid/out_ready output handshake; result held until accepted
//   dout                unsigned result (2*WIDTH bits; upper half zero in mode 1)
//   tag_out, mode_out   tag and mode of the sample currently in dout
module math_cabs_seq #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     dina,
    input  logic [WIDTH-1:0]     dinb,
    input  logic                 mode,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   dout,
    output logic [TAG_W-1:0]     tag_out,
    output logic                 mode_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SQUARE, SQRT, DONE} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0]   a_r, b_r;
    logic                      mode_r;
    logic [TAG_W-1:0]          tag_r;
    logic                      sq_stage;
    logic [2*WIDTH-1:0]        pa_r, pb_r;
    logic [2*WIDTH-1:0]        sum;
    logic signed [2*WIDTH-1:0] ax, bx;

    logic [2*WIDTH-1:0]        rad;
    logic [WIDTH-1:0]          root;
    logic [WIDTH+1:0]          rem;
    logic [CW-1:0]             cnt;

    logic [WIDTH+3:0]          rem_sh, trial, diff;
    logic                      ge;
    logic [WIDTH-1:0]          root_nxt;
    logic [WIDTH+1:0]          rem_nxt;
    logic                      round_up;
    logic [WIDTH-1:0]          res;

    assign ax  = {{WIDTH{a_r[WIDTH-1]}}, a_r};
    assign bx  = {{WIDTH{b_r[WIDTH-1]}}, b_r};
    assign sum = pa_r + pb_r;

    // One restoring square-root step: bring down the next two radicand bits
    // and try subtracting 4*root + 1.
    always_comb begin
        rem_sh   = {rem, rad[2*WIDTH-1:2*WIDTH-2]};
        trial    = {2'b00, root, 2'b01};
        diff     = rem_sh - trial;
        ge       = (rem_sh >= trial);
        root_nxt = {root[WIDTH-2:0], ge};
        rem_nxt  = ge ? diff[WIDTH+1:0] : rem_sh[WIDTH+1:0];
        round_up = (ROUND != 0) && (rem_nxt > {2'b00, root_nxt});
        res      = root_nxt + WIDTH'(round_up);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = SQUARE;
            SQUARE: if (sq_stage) state_nxt = mode_r ? SQRT : DONE;
            SQRT:   if (cnt == '0) state_nxt = DONE;
            DONE:   if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath. SQUARE spends two cycles: the products are registered before
    // the add so the two wide multiplies stay off the adder path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            mode_r   <= 1'b0;
            tag_r    <= '0;
            sq_stage <= 1'b0;
            pa_r     <= '0;
            pb_r     <= '0;
            rad      <= '0;
            root     <= '0;
            rem      <= '0;
            cnt      <= '0;
            dout     <= '0;
            tag_out  <= '0;
            mode_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sq_stage <= 1'b0;
                    if (in_valid) begin
                        a_r    <= dina;
                        b_r    <= dinb;
                        mode_r <= mode;
                        tag_r  <= tag_in;
                    end
                end
                SQUARE: begin
                    if (!sq_stage) begin
                        pa_r     <= ax * ax;
                        pb_r     <= bx * bx;
                        sq_stage <= 1'b1;
                    end else if (mode_r) begin
                        rad  <= sum;
                        root <= '0;
                        rem  <= '0;
                        cnt  <= CW'(WIDTH - 1);
                    end else begin
                        dout     <= sum;
                        tag_out  <= tag_r;
                        mode_out <= mode_r;
                    end
                end
                SQRT: begin
                    rad  <= {rad[2*WIDTH-3:0], 2'b00};
                    root <= root_nxt;
                    rem  <= rem_nxt;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        dout     <= {{WIDTH{1'b0}}, res};
                        tag_out  <= tag_r;
                        mode_out <= mode_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
